scp_control_unit: RTL and testbench
===================================

SCP_CONTROL_UNIT -- requirements
Module: scp_control_unit

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles to empty the pipeline after HALT.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  single-cycle request to begin or resume execution.
REQ-005 SHALL have port opCode  in  3  opcode of the instruction currently in fetch (IM_Dbus[15:13]).
REQ-006 SHALL have port AluZero  in  1  zero flag of the execute-stage ALU result.
REQ-007 SHALL have port en  out  1  pipeline-register enable.
REQ-008 SHALL have port PcRun  out  1  PC advance enable.
REQ-009 SHALL have ports AddMul, AndNot, AcMem, LoadAcc, MemSel, AcSel, PcSel, Wr, Rd  out  1 each  fetch-stage control bits.
REQ-010 SHALL have ports WbSel  out  2  write-back select, and halted  out  1  HALTED-state flag.

Function
REQ-011 SHALL decode opcodes as 000 HALT, 001 LOAD, 010 STORE, 011 ADD, 100 MUL, 101 AND, 110 NOT, 111 JZ.
REQ-012 SHALL encode the ALU op as {AndNot,AddMul}: 00 ADD, 01 MUL, 10 AND, 11 NOT.
REQ-013 SHALL encode WbSel as 00 accumulator, 01 memory, 11 ALU.
REQ-014 LOAD SHALL drive Rd=1, LoadAcc=1, AcMem=1, WbSel=01.
REQ-015 STORE SHALL drive Wr=1, AcMem=0, WbSel=00.
REQ-016 ADD/MUL/AND SHALL drive AcSel=1, MemSel=1, Rd=1, LoadAcc=1, AcMem=1, WbSel=11, with the ALU op from REQ-012.
REQ-017 NOT SHALL drive AcSel=1, MemSel=0, Rd=0, LoadAcc=1, AcMem=1, WbSel=11, {AndNot,AddMul}=11.
REQ-018 A NOP (all control bits and WbSel 0) SHALL be issued whenever the state is not RUN, and on any stall, HALT or JZ cycle.
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN and HALTED:
- IDLE -> RUN on start.
- RUN -> DRAIN on HALT in fetch.
- DRAIN -> HALTED when the drain counter reaches 0.
- HALTED -> RUN on start.
- start SHALL be ignored in RUN and DRAIN.
REQ-020 en SHALL be 1 in RUN and DRAIN and 0 in IDLE and HALTED; PcRun SHALL be 1 only in RUN when no stall or HALT is present.
REQ-021 SHALL keep a 2-bit in-flight ALU scoreboard {exec,decode}. When en=1, each cycle it shifts in 1 if an ALU op (011-110) is issued, else 0.
REQ-022 SHALL keep a flag register Z, loaded with AluZero in each cycle the scoreboard exec bit is 1.
REQ-023 A JZ in fetch while either scoreboard bit is 1 SHALL stall: PcRun=0, NOP issued, PC held. The stall SHALL last at most 2 cycles.
REQ-024 An unstalled JZ SHALL drive PcSel=Z and PcRun=1, issued in the same cycle (0-cycle decode latency).
REQ-025 On HALT, the drain counter SHALL load DRAIN_CYCLES-1 and decrement once per DRAIN cycle; halted SHALL assert on entry to HALTED.
REQ-026 Leaving HALTED or IDLE SHALL clear the scoreboard but SHALL keep Z.
REQ-027 If start and HALT occur in the same cycle in RUN, HALT SHALL win.

Reset
REQ-028 While reset=0, SHALL asynchronously force state IDLE, all outputs 0, Z=0, scoreboard 00 and drain counter 0.
REQ-029 Deassertion SHALL take effect at the next rising clk; reset mid-DRAIN SHALL abort the drain and land in IDLE.

Structure
REQ-030 Opcode constants, ALU-op and WbSel encodings, and the FSM state type SHALL live in shared package scp_pkg.
REQ-031 The opcode-to-control table SHALL be a combinational sub-module scp_decoder; the FSM, scoreboard, Z and drain counter SHALL stay in scp_control_unit.

Verification
REQ-032 Reset then start pulse, opCode=001 -> next cycle en=1, PcRun=1, Rd=1, LoadAcc=1, AcMem=1, WbSel=01.
REQ-033 Issue ADD (011) then JZ (111) -> JZ stalls 2 cycles (PcRun=0, NOPs), then PcSel equals the AluZero sampled at ADD execute.
REQ-034 AND yielding AluZero=1 retired, then JZ with scoreboard 00 -> PcSel=1, PcRun=1 in the same cycle, no stall.
REQ-035 HALT (000) in RUN -> PcRun=0, en=1 for 3 cycles, then halted=1 and en=0; a start pulse returns to RUN with halted=0.
REQ-036 reset pulled low during DRAIN, asynchronous to clk -> outputs 0 immediately; after release, stays IDLE until start.

Source files
------------

// File: rtl/scp_pkg.sv
// Shared encodings for the SCP control path: opcodes, ALU op, write-back select and FSM states.
package scp_pkg;

  localparam logic [2:0] OP_HALT  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_NOT   = 3'b110;
  localparam logic [2:0] OP_JZ    = 3'b111;

  // ALU op is {AndNot,AddMul}
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_MUL = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] WB_ACC = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_ALU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  function automatic logic isAluOp(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/scp_decoder.sv
// Combinational opcode-to-control table; HALT and JZ decode to NOP here, the
// control unit adds PcSel for JZ and gates everything by state and stall.
module scp_decoder
  import scp_pkg::*;
(
  input  logic [2:0] opCode,
  output logic [1:0] aluOp,
  output logic       acMem,
  output logic       loadAcc,
  output logic       memSel,
  output logic       acSel,
  output logic       wr,
  output logic       rd,
  output logic [1:0] wbSel,
  output logic       isAlu
);

  always_comb begin
    aluOp   = ALU_ADD;
    acMem   = 1'b0;
    loadAcc = 1'b0;
    memSel  = 1'b0;
    acSel   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    wbSel   = WB_ACC;
    isAlu   = isAluOp(opCode);
    case (opCode)
      OP_LOAD: begin
        rd      = 1'b1;
        loadAcc = 1'b1;
        acMem   = 1'b1;
        wbSel   = WB_MEM;
      end
      OP_STORE: begin
        wr    = 1'b1;
        wbSel = WB_ACC;
      end
      OP_ADD, OP_MUL, OP_AND: begin
        acSel   = 1'b1;
        memSel  = 1'b1;
        rd      = 1'b1;
        loadAcc = 1'b1;
        acMem   = 1'b1;
        wbSel   = WB_ALU;
        aluOp   = (opCode == OP_ADD) ? ALU_ADD :
                  (opCode == OP_MUL) ? ALU_MUL : ALU_AND;
      end
      OP_NOT: begin
        acSel   = 1'b1;
        loadAcc = 1'b1;
        acMem   = 1'b1;
        wbSel   = WB_ALU;
        aluOp   = ALU_NOT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/scp_control_unit.sv
// SCP pipeline controller: run/drain/halt FSM, ALU scoreboard for JZ hazards, Z flag.
// Control outputs are combinational from state and the fetched opcode (0-cycle decode).
module scp_control_unit
  import scp_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opCode,
  input  logic       AluZero,
  output logic       en,
  output logic       PcRun,
  output logic       AddMul,
  output logic       AndNot,
  output logic       AcMem,
  output logic       LoadAcc,
  output logic       MemSel,
  output logic       AcSel,
  output logic       PcSel,
  output logic       Wr,
  output logic       Rd,
  output logic [1:0] WbSel,
  output logic       halted
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state, stateNxt;
  logic [1:0]      sb;
  logic            zFlag;
  logic [CW-1:0]   drainCnt;

  logic [1:0] dAluOp;
  logic       dAcMem, dLoadAcc, dMemSel, dAcSel, dWr, dRd, dIsAlu;
  logic [1:0] dWbSel;

  scp_decoder uDec (
    .opCode  (opCode),
    .aluOp   (dAluOp),
    .acMem   (dAcMem),
    .loadAcc (dLoadAcc),
    .memSel  (dMemSel),
    .acSel   (dAcSel),
    .wr      (dWr),
    .rd      (dRd),
    .wbSel   (dWbSel),
    .isAlu   (dIsAlu)
  );

  logic inRun, isHalt, isJz, stall, issue, aluIssued;

  assign inRun     = (state == ST_RUN);
  assign isHalt    = (opCode == OP_HALT);
  assign isJz      = (opCode == OP_JZ);
  // A JZ must wait until every in-flight ALU op has updated Z.
  assign stall     = inRun && isJz && (sb != 2'b00);
  assign issue     = inRun && !stall && !isHalt;
  assign aluIssued = issue && dIsAlu;

  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE:   if (start) stateNxt = ST_RUN;
      ST_RUN:    if (isHalt) stateNxt = ST_DRAIN;
      ST_DRAIN:  if (drainCnt == '0) stateNxt = ST_HALTED;
      ST_HALTED: if (start) stateNxt = ST_RUN;
      default:   stateNxt = ST_IDLE;
    endcase
  end

  always_comb begin
    en      = (state == ST_RUN) || (state == ST_DRAIN);
    halted  = (state == ST_HALTED);
    PcRun   = issue;
    AddMul  = 1'b0;
    AndNot  = 1'b0;
    AcMem   = 1'b0;
    LoadAcc = 1'b0;
    MemSel  = 1'b0;
    AcSel   = 1'b0;
    PcSel   = 1'b0;
    Wr      = 1'b0;
    Rd      = 1'b0;
    WbSel   = WB_ACC;
    if (issue) begin
      {AndNot, AddMul} = dAluOp;
      AcMem   = dAcMem;
      LoadAcc = dLoadAcc;
      MemSel  = dMemSel;
      AcSel   = dAcSel;
      Wr      = dWr;
      Rd      = dRd;
      WbSel   = dWbSel;
      PcSel   = isJz && zFlag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      sb       <= 2'b00;
      zFlag    <= 1'b0;
      drainCnt <= '0;
    end else begin
      state <= stateNxt;
      if (en && sb[1])
        zFlag <= AluZero;
      // Restarting begins with an empty pipeline; Z survives the restart.
      if ((state == ST_IDLE || state == ST_HALTED) && stateNxt == ST_RUN)
        sb <= 2'b00;
      else if (en)
        sb <= {sb[0], aluIssued};
      if (inRun && isHalt)
        drainCnt <= CW'(DRAIN_CYCLES - 1);
      else if (state == ST_DRAIN && drainCnt != '0)
        drainCnt <= drainCnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_scp_control_unit.sv
// Directed-vector bench for scp_control_unit; outputs compared as one packed word per cycle.
module tb_scp_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] opCode;
  logic       AluZero;
  logic       en, PcRun, AddMul, AndNot, AcMem, LoadAcc, MemSel, AcSel, PcSel, Wr, Rd, halted;
  logic [1:0] WbSel;

  int vecCnt = 0;
  int errCnt = 0;

  always #5 clk = ~clk;

  scp_control_unit #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .opCode(opCode), .AluZero(AluZero),
    .en(en), .PcRun(PcRun), .AddMul(AddMul), .AndNot(AndNot), .AcMem(AcMem),
    .LoadAcc(LoadAcc), .MemSel(MemSel), .AcSel(AcSel), .PcSel(PcSel), .Wr(Wr),
    .Rd(Rd), .WbSel(WbSel), .halted(halted)
  );

  // Field order: en PcRun AddMul AndNot AcMem LoadAcc MemSel AcSel PcSel Wr Rd WbSel[1:0] halted
  logic [13:0] outv;
  assign outv = {en, PcRun, AddMul, AndNot, AcMem, LoadAcc, MemSel, AcSel, PcSel, Wr, Rd, WbSel, halted};

  localparam logic [13:0] V_ZERO   = 14'b0_0_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] V_HOLD   = 14'b1_0_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] V_LOAD   = 14'b1_1_0_0_1_1_0_0_0_0_1_01_0;
  localparam logic [13:0] V_STORE  = 14'b1_1_0_0_0_0_0_0_0_1_0_00_0;
  localparam logic [13:0] V_ADD    = 14'b1_1_0_0_1_1_1_1_0_0_1_11_0;
  localparam logic [13:0] V_MUL    = 14'b1_1_1_0_1_1_1_1_0_0_1_11_0;
  localparam logic [13:0] V_AND    = 14'b1_1_0_1_1_1_1_1_0_0_1_11_0;
  localparam logic [13:0] V_NOT    = 14'b1_1_1_1_1_1_0_1_0_0_0_11_0;
  localparam logic [13:0] V_JZ_T   = 14'b1_1_0_0_0_0_0_0_1_0_0_00_0;
  localparam logic [13:0] V_JZ_N   = 14'b1_1_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] V_HALTED = 14'b0_0_0_0_0_0_0_0_0_0_0_00_1;

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check the combinational outputs.
  task automatic cyc(input logic s, input logic [2:0] op, input logic z,
                     input string tag, input logic [13:0] exp);
    @(negedge clk);
    start   = s;
    opCode  = op;
    AluZero = z;
    #1;
    chk(tag, outv, exp);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opCode = 3'b001; AluZero = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_out", outv, V_ZERO);
    @(negedge clk);
    reset = 1'b1;

    cyc(0, 3'b001, 0, "idle_hold",  V_ZERO);
    cyc(1, 3'b001, 0, "idle_start", V_ZERO);
    cyc(0, 3'b001, 0, "run_load",   V_LOAD);
    cyc(0, 3'b010, 0, "run_store",  V_STORE);
    cyc(0, 3'b011, 0, "run_add",    V_ADD);
    cyc(0, 3'b111, 0, "jz_stall1",  V_HOLD);
    cyc(0, 3'b111, 1, "jz_stall2",  V_HOLD);   // ADD executes with AluZero=1
    cyc(0, 3'b111, 0, "jz_taken",   V_JZ_T);

    cyc(0, 3'b100, 0, "run_mul",    V_MUL);
    cyc(0, 3'b110, 1, "run_not",    V_NOT);    // exec bit 0: AluZero ignored
    cyc(0, 3'b001, 0, "load_b2b",   V_LOAD);   // MUL exec -> Z=0
    cyc(0, 3'b010, 0, "store_b2b",  V_STORE);  // NOT exec -> Z=0
    cyc(0, 3'b111, 1, "jz_not_tkn", V_JZ_N);

    cyc(0, 3'b101, 0, "run_and",    V_AND);
    cyc(0, 3'b001, 0, "load_a",     V_LOAD);
    cyc(1, 3'b010, 1, "store_start",V_STORE);  // AND exec -> Z=1; start ignored
    cyc(0, 3'b111, 0, "jz_nostall", V_JZ_T);

    cyc(1, 3'b000, 0, "halt_start", V_HOLD);
    cyc(0, 3'b001, 0, "drain1",     V_HOLD);
    cyc(1, 3'b011, 0, "drain2",     V_HOLD);
    cyc(0, 3'b001, 0, "drain3",     V_HOLD);
    cyc(0, 3'b001, 0, "halted",     V_HALTED);
    cyc(1, 3'b001, 0, "halted_st",  V_HALTED);
    cyc(0, 3'b111, 0, "resume_jz",  V_JZ_T);   // Z kept across halt
    cyc(0, 3'b011, 0, "resume_add", V_ADD);

    cyc(0, 3'b000, 0, "halt2",      V_HOLD);
    cyc(0, 3'b001, 0, "drain_a",    V_HOLD);
    #2 reset = 1'b0;
    #1 chk("async_rst", outv, V_ZERO);
    @(negedge clk);
    #1 chk("rst_held", outv, V_ZERO);
    reset = 1'b1;
    cyc(0, 3'b001, 0, "post_idle1", V_ZERO);
    cyc(0, 3'b011, 0, "post_idle2", V_ZERO);
    cyc(1, 3'b001, 0, "post_start", V_ZERO);
    cyc(0, 3'b001, 0, "post_load",  V_LOAD);
    cyc(0, 3'b111, 0, "post_jz_z0", V_JZ_N);   // reset cleared Z

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
